// File: rtl/axis_pkt_pkg.sv
// rtl/axis_pkt_pkg.sv - shared FSM encoding and output flag layout for the packet framer
package axis_pkt_pkg;

   typedef enum logic [1:0] {
      ST_SOP  = 2'd0,
      ST_BODY = 2'd1,
      ST_DROP = 2'd2
   } framer_state_t;

   localparam int FLAG_SOP   = 0;
   localparam int FLAG_TRUNC = 1;
   localparam int FLAG_TLAST = 2;
   localparam int FLAG_W     = 3;

endpackage

// File: rtl/axis_pkt_out_reg.sv
// rtl/axis_pkt_out_reg.sv - one-entry valid/ready output register, payload reads zero while empty
module axis_pkt_out_reg
   import axis_pkt_pkg::*;
#(
   parameter int TUSER_WIDTH = 128,
   parameter int TDATA_WIDTH = 256,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [FLAG_W-1:0]      load_flags,
   input  logic [IDX_WIDTH-1:0]   load_beat_idx,
   input  logic [TUSER_WIDTH-1:0] load_tuser,
   input  logic [TDATA_WIDTH-1:0] load_tdata,
   output logic                   load_ready,
   output logic                   out_tvalid,
   output logic [FLAG_W-1:0]      out_flags,
   output logic [IDX_WIDTH-1:0]   out_beat_idx,
   output logic [TUSER_WIDTH-1:0] out_tuser,
   output logic [TDATA_WIDTH-1:0] out_tdata,
   input  logic                   out_tready
);

   localparam int PAYLOAD_W = FLAG_W + IDX_WIDTH + TUSER_WIDTH + TDATA_WIDTH;

   logic [PAYLOAD_W-1:0] payload_q;

   assign load_ready = ~out_tvalid | out_tready;

   // A load in the same cycle as a drain simply overwrites, so a full stream never bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_tvalid <= 1'b0;
         payload_q  <= '0;
      end else if (load) begin
         out_tvalid <= 1'b1;
         payload_q  <= {load_flags, load_beat_idx, load_tuser, load_tdata};
      end else if (out_tvalid & out_tready) begin
         out_tvalid <= 1'b0;
         payload_q  <= '0;
      end
   end

   assign {out_flags, out_beat_idx, out_tuser, out_tdata} = payload_q;

endmodule

// File: rtl/axis_pkt_framer.sv
// rtl/axis_pkt_framer.sv - per-packet annotation (sop, tuser hold, beat index) with truncation at MAX_BEATS
module axis_pkt_framer
   import axis_pkt_pkg::*;
#(
   parameter int TUSER_WIDTH = 128,
   parameter int TDATA_WIDTH = 256,
   parameter int MAX_BEATS   = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0]       s_axis_tuser,
   input  logic [TDATA_WIDTH-1:0]       s_axis_tdata,
   output logic                         s_axis_tready,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   output logic [TUSER_WIDTH-1:0]       m_axis_tuser,
   output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
   output logic                         m_axis_sop,
   output logic [$clog2(MAX_BEATS)-1:0] m_axis_beat_idx,
   output logic                         m_axis_trunc,
   input  logic                         m_axis_tready,
   output logic [CNT_WIDTH-1:0]         pkt_cnt,
   output logic [CNT_WIDTH-1:0]         trunc_cnt
);

   localparam int               IDX_W    = $clog2(MAX_BEATS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BEATS - 1);

   framer_state_t          state, state_nxt;
   logic [IDX_W-1:0]       beat_cnt;
   logic [TUSER_WIDTH-1:0] tuser_hold;
   logic                   reg_ready;
   logic                   accept;
   logic                   force_last;
   logic [FLAG_W-1:0]      o_flags;
   logic [IDX_W-1:0]       o_idx;
   logic [TUSER_WIDTH-1:0] o_tuser;
   logic [FLAG_W-1:0]      m_flags;

   // DROP swallows input regardless of downstream back-pressure.
   assign s_axis_tready = (state == ST_DROP) ? 1'b1 : reg_ready;
   assign accept        = s_axis_tvalid & s_axis_tready & (state != ST_DROP);
   assign force_last    = (state == ST_BODY) & ~s_axis_tlast & (beat_cnt == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_SOP;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_SOP:  if (accept & ~s_axis_tlast) state_nxt = ST_BODY;
         ST_BODY: begin
            if (accept & s_axis_tlast)    state_nxt = ST_SOP;
            else if (accept & force_last) state_nxt = ST_DROP;
         end
         ST_DROP: if (s_axis_tvalid & s_axis_tlast) state_nxt = ST_SOP;
         default: state_nxt = ST_SOP;
      endcase
   end

   always_comb begin
      o_flags   = '0;
      o_idx     = '0;
      o_tuser   = tuser_hold;
      if (state == ST_SOP) begin
         o_flags[FLAG_SOP] = 1'b1;
         o_tuser           = s_axis_tuser;
      end else begin
         o_idx = beat_cnt;
      end
      o_flags[FLAG_TLAST] = s_axis_tlast | force_last;
      o_flags[FLAG_TRUNC] = force_last;
   end

   // beat_cnt is always 0 in SOP, so the common increment also yields 1 after a first beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt   <= '0;
         tuser_hold <= '0;
      end else if (accept) begin
         if (state == ST_SOP) tuser_hold <= s_axis_tuser;
         if (s_axis_tlast | force_last) beat_cnt <= '0;
         else                           beat_cnt <= beat_cnt + 1'b1;
      end else if ((state == ST_DROP) & s_axis_tvalid & s_axis_tlast) begin
         beat_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt   <= '0;
         trunc_cnt <= '0;
      end else begin
         if (m_axis_tvalid & m_axis_tready & m_axis_tlast) pkt_cnt   <= pkt_cnt + 1'b1;
         if (accept & force_last)                          trunc_cnt <= trunc_cnt + 1'b1;
      end
   end

   axis_pkt_out_reg #(
      .TUSER_WIDTH (TUSER_WIDTH),
      .TDATA_WIDTH (TDATA_WIDTH),
      .IDX_WIDTH   (IDX_W)
   ) u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .load          (accept),
      .load_flags    (o_flags),
      .load_beat_idx (o_idx),
      .load_tuser    (o_tuser),
      .load_tdata    (s_axis_tdata),
      .load_ready    (reg_ready),
      .out_tvalid    (m_axis_tvalid),
      .out_flags     (m_flags),
      .out_beat_idx  (m_axis_beat_idx),
      .out_tuser     (m_axis_tuser),
      .out_tdata     (m_axis_tdata),
      .out_tready    (m_axis_tready)
   );

   assign m_axis_tlast = m_flags[FLAG_TLAST];
   assign m_axis_trunc = m_flags[FLAG_TRUNC];
   assign m_axis_sop   = m_flags[FLAG_SOP];

endmodule

// File: tb/tb_axis_pkt_framer.sv
// tb/tb_axis_pkt_framer.sv - packet-level reference model, directed cases and randomized traffic for axis_pkt_framer
module tb_axis_pkt_framer;

   localparam int TUW  = 16;
   localparam int TDW  = 32;
   localparam int MAXB = 16;
   localparam int CW   = 32;
   localparam int IW   = $clog2(MAXB);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           s_tvalid = 1'b0;
   logic           s_tlast = 1'b0;
   logic [TUW-1:0] s_tuser = '0;
   logic [TDW-1:0] s_tdata = '0;
   logic           s_tready;
   logic           m_tvalid, m_tlast, m_sop, m_trunc;
   logic [TUW-1:0] m_tuser;
   logic [TDW-1:0] m_tdata;
   logic [IW-1:0]  m_idx;
   logic           m_tready;
   logic [CW-1:0]  pkt_cnt, trunc_cnt;

   logic rand_ready = 1'b0;
   logic rnd_ready = 1'b1;
   logic forced_ready = 1'b1;
   assign m_tready = rand_ready ? rnd_ready : forced_ready;

   typedef struct {
      logic [TDW-1:0] tdata;
      logic [TUW-1:0] tuser;
      logic [IW-1:0]  idx;
      logic           sop;
      logic           tlast;
      logic           trunc;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       out_log[$];
   int          checks = 0;
   int          failures = 0;
   int          k = 0;
   logic [TUW-1:0] pkt_tuser = '0;
   int unsigned m_pkt = 0;
   int unsigned m_trunc_n = 0;

   axis_pkt_framer #(
      .TUSER_WIDTH (TUW),
      .TDATA_WIDTH (TDW),
      .MAX_BEATS   (MAXB),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis_tvalid   (s_tvalid),
      .s_axis_tlast    (s_tlast),
      .s_axis_tuser    (s_tuser),
      .s_axis_tdata    (s_tdata),
      .s_axis_tready   (s_tready),
      .m_axis_tvalid   (m_tvalid),
      .m_axis_tlast    (m_tlast),
      .m_axis_tuser    (m_tuser),
      .m_axis_tdata    (m_tdata),
      .m_axis_sop      (m_sop),
      .m_axis_beat_idx (m_idx),
      .m_axis_trunc    (m_trunc),
      .m_axis_tready   (m_tready),
      .pkt_cnt         (pkt_cnt),
      .trunc_cnt       (trunc_cnt)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: input beat k of a packet (counting dropped beats) maps to output beat k while k < MAXB.
   always @(negedge clk) begin
      beat_t e;
      beat_t o;
      if (rst) begin
         chk("rst_m_tvalid", m_tvalid, 0);
         chk("rst_pkt_cnt", pkt_cnt, 0);
         chk("rst_trunc_cnt", trunc_cnt, 0);
         exp_q.delete();
         k         = 0;
         m_pkt     = 0;
         m_trunc_n = 0;
      end else begin
         chk("m_tvalid", m_tvalid, exp_q.size() != 0);
         if (m_tvalid && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("m_tdata", m_tdata, e.tdata);
            chk("m_tuser", m_tuser, e.tuser);
            chk("m_beat_idx", m_idx, e.idx);
            chk("m_sop", m_sop, e.sop);
            chk("m_tlast", m_tlast, e.tlast);
            chk("m_trunc", m_trunc, e.trunc);
         end
         if (!m_tvalid)
            chk("idle_payload_zero", {m_tlast, m_trunc, m_sop, m_idx, m_tuser, m_tdata}, 0);
         chk("s_tready", s_tready, (k >= MAXB) ? 1'b1 : (exp_q.size() == 0 || m_tready));
         chk("pkt_cnt", pkt_cnt, m_pkt);
         chk("trunc_cnt", trunc_cnt, m_trunc_n);
         if (m_tvalid && m_tready) begin
            o.tdata = m_tdata; o.tuser = m_tuser; o.idx = m_idx;
            o.sop = m_sop; o.tlast = m_tlast; o.trunc = m_trunc;
            out_log.push_back(o);
            if (exp_q.size() != 0) begin
               if (exp_q[0].tlast) m_pkt++;
               void'(exp_q.pop_front());
            end
         end
         if (s_tvalid && s_tready) begin
            if (k < MAXB) begin
               if (k == 0) pkt_tuser = s_tuser;
               e.tdata = s_tdata;
               e.tuser = pkt_tuser;
               e.idx   = IW'(k);
               e.sop   = (k == 0);
               e.trunc = (k == MAXB - 1) && !s_tlast;
               e.tlast = s_tlast || e.trunc;
               if (e.trunc) m_trunc_n++;
               exp_q.push_back(e);
            end
            k = s_tlast ? 0 : k + 1;
         end
      end
   end

   task automatic send_beat(input logic [TDW-1:0] d, input logic [TUW-1:0] u, input logic l);
      logic ok;
      ok       = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      chk("send_accepted", ok, 1);
      s_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int len, input logic [TUW-1:0] u0, input logic [TUW-1:0] urest,
                           input logic [TDW-1:0] d0);
      for (int i = 0; i < len; i++)
         send_beat(d0 + TDW'(i), (i == 0) ? u0 : urest, i == len - 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!m_tvalid) break;
      end
      chk("drained", m_tvalid, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      longint t0;
      #1 rst = 1'b1;
      @(negedge clk);
      chk("reset_m_tvalid", m_tvalid, 0);
      chk("reset_pkt_cnt", pkt_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_s_tready", s_tready, 1);
      idle(1);

      // single-beat packet, seen one cycle after acceptance
      base = out_log.size();
      send_beat(32'h1000, 16'h00A5, 1'b1);
      @(negedge clk);
      chk("one_valid", m_tvalid, 1);
      chk("one_sop", m_sop, 1);
      chk("one_tlast", m_tlast, 1);
      chk("one_idx", m_idx, 0);
      chk("one_tuser", m_tuser, 16'h00A5);
      @(posedge clk);
      #1;
      wait_drain();
      chk("one_pkt_cnt", pkt_cnt, 1);

      // tuser held from first beat
      base = out_log.size();
      send_pkt(4, 16'h0011, 16'h00FF, 32'h2000);
      wait_drain();
      chk("four_count", out_log.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk("four_tuser", out_log[base+i].tuser, 16'h0011);
         chk("four_idx", out_log[base+i].idx, IW'(i));
         chk("four_sop", out_log[base+i].sop, i == 0);
      end
      chk("four_pkt_cnt", pkt_cnt, 2);

      // 20-beat packet truncated to 16
      base = out_log.size();
      send_pkt(20, 16'h0020, 16'h0021, 32'h3000);
      wait_drain();
      chk("trunc_count", out_log.size() - base, 16);
      chk("trunc_b14_tlast", out_log[base+14].tlast, 0);
      chk("trunc_b15_tlast", out_log[base+15].tlast, 1);
      chk("trunc_b15_trunc", out_log[base+15].trunc, 1);
      chk("trunc_trunc_cnt", trunc_cnt, 1);
      chk("trunc_pkt_cnt", pkt_cnt, 3);

      // exactly MAX_BEATS: native tlast, no truncation
      base = out_log.size();
      send_pkt(16, 16'h0030, 16'h0031, 32'h4000);
      wait_drain();
      chk("exact_count", out_log.size() - base, 16);
      chk("exact_b15_tlast", out_log[base+15].tlast, 1);
      chk("exact_b15_trunc", out_log[base+15].trunc, 0);
      chk("exact_trunc_cnt", trunc_cnt, 1);
      base = out_log.size();
      send_pkt(1, 16'h0040, 16'h0040, 32'h4800);
      wait_drain();
      chk("after_exact_sop", out_log[base].sop, 1);
      chk("after_exact_pkt_cnt", pkt_cnt, 5);

      // back-pressure mid-packet for 5 cycles
      base = out_log.size();
      send_beat(32'h5000, 16'h0050, 1'b0);
      send_beat(32'h5001, 16'h0051, 1'b0);
      forced_ready = 1'b0;
      fork
         for (int i = 2; i < 8; i++) send_beat(32'h5000 + TDW'(i), 16'h0051, i == 7);
         begin
            repeat (5) @(negedge clk);
            chk("bp_s_tready", s_tready, 0);
            chk("bp_m_tvalid", m_tvalid, 1);
            chk("bp_held_data", m_tdata, 32'h5001);
            chk("bp_held_idx", m_idx, 1);
            @(posedge clk);
            #1 forced_ready = 1'b1;
         end
      join
      wait_drain();
      chk("bp_count", out_log.size() - base, 8);
      for (int i = 0; i < 8; i++) chk("bp_data", out_log[base+i].tdata, 32'h5000 + TDW'(i));
      chk("bp_pkt_cnt", pkt_cnt, 6);

      // full throughput with m_tready held high
      t0 = $time;
      send_pkt(8, 16'h0060, 16'h0061, 32'h6000);
      chk("throughput_cycles", ($time - t0) / 10, 8);
      wait_drain();
      chk("tp_pkt_cnt", pkt_cnt, 7);

      // asynchronous reset in the middle of a 6-beat packet
      send_beat(32'h7000, 16'h0070, 1'b0);
      send_beat(32'h7001, 16'h0071, 1'b0);
      send_beat(32'h7002, 16'h0071, 1'b0);
      #2;
      chk("pre_rst_valid", m_tvalid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", m_tvalid, 0);
      chk("async_rst_data", m_tdata, 0);
      chk("async_rst_pkt_cnt", pkt_cnt, 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      base = out_log.size();
      send_beat(32'h7100, 16'h0077, 1'b0);
      send_beat(32'h7101, 16'h0088, 1'b1);
      wait_drain();
      chk("post_rst_sop", out_log[base].sop, 1);
      chk("post_rst_idx", out_log[base].idx, 0);
      chk("post_rst_tuser", out_log[base+1].tuser, 16'h0077);
      chk("post_rst_b1_idx", out_log[base+1].idx, 1);
      chk("post_rst_pkt_cnt", pkt_cnt, 1);

      // randomized packets, gaps and back-pressure
      rand_ready = 1'b1;
      for (int p = 0; p < 80; p++) begin
         int len;
         logic [TUW-1:0] u0;
         len = $urandom_range(1, 22);
         u0  = TUW'($urandom);
         for (int i = 0; i < len; i++) begin
            send_beat(TDW'($urandom), (i == 0) ? u0 : TUW'($urandom), i == len - 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      rand_ready = 1'b0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
